// File: rtl/dmem_arbiter_pkg.sv
// Shared types and default sizes for the data-memory arbiter.
package dmem_arb_pkg;

    localparam int ADDR_W_DEF = 9;
    localparam int DATA_W_DEF = 32;
    localparam int CNT_W_DEF  = 16;

    // Which requester owns an access (grant history, read return routing).
    typedef enum logic {
        OWN_CPU = 1'b0,
        OWN_LD  = 1'b1
    } owner_t;

    // One memory access as presented to the RAM (default configuration).
    typedef struct packed {
        logic                  we;
        logic [ADDR_W_DEF-1:0] addr;
        logic [DATA_W_DEF-1:0] wdata;
    } mem_req_t;

endpackage

// File: rtl/dmem_arbiter_rr_arbiter2.sv
// Two-way round-robin grant core: index 0 is the CPU, index 1 the loader.
// Grant is combinational; only the grant history is registered.
module rr_arbiter2
    import dmem_arb_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       adv,
    output logic [1:0] gnt
);

    owner_t last_owner;

    // Pick the winner: a lone requester wins, a tie goes to whoever did not win last.
    always_comb begin
        gnt = 2'b00;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = (last_owner == OWN_CPU) ? 2'b10 : 2'b01;
            default: gnt = 2'b00;
        endcase
    end

    // Remember the last granted owner; idle cycles leave the history untouched.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_owner <= OWN_LD;
        end else if (adv) begin
            last_owner <= gnt[1] ? OWN_LD : OWN_CPU;
        end else begin
            last_owner <= last_owner;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the single-port data RAM between the core data port and a
// loader/debug port. One access per cycle, round-robin on ties, reads
// return one cycle after issue, and a saturating counter tracks contention.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_rd,
    input  logic              cpu_wr,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_stall,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              ld_req,
    input  logic              ld_we,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_wdata,
    output logic              ld_gnt,
    output logic              ld_rvalid,
    output logic [DATA_W-1:0] ld_rdata,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_din,
    input  logic [DATA_W-1:0] ram_dout,
    output logic [CNT_W-1:0]  contention_cnt
);

    logic       cpu_req;
    logic [1:0] req_vec;
    logic [1:0] gnt;
    logic       cpu_win;
    logic       ld_win;
    logic       any_gnt;
    logic       rd_pending;
    owner_t     rd_owner;

    // A simultaneous read+write from the core is treated as a write.
    assign cpu_req = cpu_rd | cpu_wr;

    // Requests are masked during reset so nothing is granted or driven.
    assign req_vec = {ld_req & ~rst, cpu_req & ~rst};

    rr_arbiter2 u_rr (
        .clk (clk),
        .rst (rst),
        .req (req_vec),
        .adv (any_gnt),
        .gnt (gnt)
    );

    assign cpu_win   = gnt[0];
    assign ld_win    = gnt[1];
    assign any_gnt   = cpu_win | ld_win;
    assign cpu_stall = cpu_req & ~cpu_win & ~rst;
    assign ld_gnt    = ld_win;

    // Steer the winner's access onto the RAM port; drive zeros when idle.
    always_comb begin
        ram_we   = 1'b0;
        ram_addr = '0;
        ram_din  = '0;
        case (gnt)
            2'b01: begin
                ram_we   = cpu_wr;
                ram_addr = cpu_addr;
                ram_din  = cpu_wdata;
            end
            2'b10: begin
                ram_we   = ld_we;
                ram_addr = ld_addr;
                ram_din  = ld_wdata;
            end
            default: begin
                ram_we   = 1'b0;
                ram_addr = '0;
                ram_din  = '0;
            end
        endcase
    end

    // Track the read issued this cycle so its data can be routed next cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_pending <= 1'b0;
            rd_owner   <= OWN_CPU;
        end else begin
            rd_pending <= any_gnt & ~ram_we;
            rd_owner   <= ld_win ? OWN_LD : OWN_CPU;
        end
    end

    // Route returning RAM data to the requester that issued the read only.
    always_comb begin
        cpu_rvalid = rd_pending & ~rst & (rd_owner == OWN_CPU);
        ld_rvalid  = rd_pending & ~rst & (rd_owner == OWN_LD);
        if (cpu_rvalid) begin
            cpu_rdata = ram_dout;
        end else begin
            cpu_rdata = '0;
        end
        if (ld_rvalid) begin
            ld_rdata = ram_dout;
        end else begin
            ld_rdata = '0;
        end
    end

    // Count cycles where both sides wanted the RAM, holding at all-ones.
    always_ff @(posedge clk) begin
        if (rst) begin
            contention_cnt <= '0;
        end else if (cpu_req && ld_req && !(&contention_cnt)) begin
            contention_cnt <= contention_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            contention_cnt <= contention_cnt;
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios followed by a
// randomized run, all checked against a behavioural model of the arbiter.
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cpu_rd = 1'b0, cpu_wr = 1'b0;
    logic [8:0]  cpu_addr = 9'd0;
    logic [31:0] cpu_wdata = 32'd0;
    logic        ld_req = 1'b0, ld_we = 1'b0;
    logic [8:0]  ld_addr = 9'd0;
    logic [31:0] ld_wdata = 32'd0;
    logic [31:0] ram_dout = 32'd0;
    logic        cpu_stall, cpu_rvalid, ld_gnt, ld_rvalid, ram_we;
    logic [31:0] cpu_rdata, ld_rdata, ram_din;
    logic [8:0]  ram_addr;
    logic [15:0] contention_cnt;
    logic        x_stall, x_crv, x_gnt, x_lrv, x_we;
    logic [31:0] x_crd, x_lrd, x_din;
    logic [8:0]  x_addr;
    logic [3:0]  x_cnt;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    dmem_arbiter dut (
        .clk(clk), .rst(rst),
        .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_stall(cpu_stall), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
        .ld_req(ld_req), .ld_we(ld_we), .ld_addr(ld_addr), .ld_wdata(ld_wdata),
        .ld_gnt(ld_gnt), .ld_rvalid(ld_rvalid), .ld_rdata(ld_rdata),
        .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din), .ram_dout(ram_dout),
        .contention_cnt(contention_cnt)
    );

    // Narrow-counter instance sharing the same stimulus, used for saturation.
    dmem_arbiter #(.CNT_W(4)) dut4 (
        .clk(clk), .rst(rst),
        .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_stall(x_stall), .cpu_rvalid(x_crv), .cpu_rdata(x_crd),
        .ld_req(ld_req), .ld_we(ld_we), .ld_addr(ld_addr), .ld_wdata(ld_wdata),
        .ld_gnt(x_gnt), .ld_rvalid(x_lrv), .ld_rdata(x_lrd),
        .ram_we(x_we), .ram_addr(x_addr), .ram_din(x_din), .ram_dout(ram_dout),
        .contention_cnt(x_cnt)
    );

    // Synchronous single-port RAM environment (read-before-write).
    logic [31:0] ram [0:511];
    always @(posedge clk) begin
        if (ram_we) ram[ram_addr] <= ram_din;
        ram_dout <= ram[ram_addr];
    end

    // Reference model state.
    logic [31:0] ref_mem [0:511];
    bit          m_last_cpu = 1'b0;
    bit          m_pv = 1'b0;
    bit          m_pcpu = 1'b0;
    logic [31:0] m_pdata = 32'd0;
    int          m_cnt = 0, m_cnt4 = 0;
    bit          m_cnt_known = 1'b0;
    int          w;
    bit          e_we, e_stall, e_gnt;
    logic [8:0]  e_addr;
    logic [31:0] e_din;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: check outputs at the falling edge, advance model at the rising edge.
    task automatic cycle();
        bit cr;
        bit both;
        @(negedge clk);
        cr   = cpu_rd | cpu_wr;
        both = cr && ld_req;
        if (rst)          w = 0;
        else if (both)    w = m_last_cpu ? 2 : 1;
        else if (cr)      w = 1;
        else if (ld_req)  w = 2;
        else              w = 0;
        e_we    = (w == 1) ? cpu_wr : ((w == 2) ? ld_we : 1'b0);
        e_addr  = (w == 1) ? cpu_addr : ((w == 2) ? ld_addr : 9'd0);
        e_din   = (w == 1) ? cpu_wdata : ((w == 2) ? ld_wdata : 32'd0);
        e_stall = !rst && cr && (w != 1);
        e_gnt   = (w == 2);
        chk("ram_we", 32'(ram_we), 32'(e_we));
        chk("ram_addr", 32'(ram_addr), 32'(e_addr));
        chk("ram_din", ram_din, e_din);
        chk("cpu_stall", 32'(cpu_stall), 32'(e_stall));
        chk("ld_gnt", 32'(ld_gnt), 32'(e_gnt));
        chk("cpu_rvalid", 32'(cpu_rvalid), 32'(m_pv && !rst && m_pcpu));
        chk("ld_rvalid", 32'(ld_rvalid), 32'(m_pv && !rst && !m_pcpu));
        chk("cpu_rdata", cpu_rdata, (m_pv && !rst && m_pcpu) ? m_pdata : 32'd0);
        chk("ld_rdata", ld_rdata, (m_pv && !rst && !m_pcpu) ? m_pdata : 32'd0);
        chk("n4_ld_gnt", 32'(x_gnt), 32'(e_gnt));
        if (m_cnt_known) begin
            chk("contention_cnt", 32'(contention_cnt), 32'(m_cnt));
            chk("contention_cnt4", 32'(x_cnt), 32'(m_cnt4));
        end
        @(posedge clk);
        if (rst) begin
            m_last_cpu  = 1'b0;
            m_pv        = 1'b0;
            m_cnt       = 0;
            m_cnt4      = 0;
            m_cnt_known = 1'b1;
        end else begin
            if (w != 0) m_last_cpu = (w == 1);
            m_pv = (w != 0) && !e_we;
            if (m_pv) begin
                m_pcpu  = (w == 1);
                m_pdata = ref_mem[e_addr];
            end
            if (e_we) ref_mem[e_addr] = e_din;
            if (both) begin
                if (m_cnt < 65535) m_cnt++;
                if (m_cnt4 < 15) m_cnt4++;
            end
        end
        #1;
    endtask

    task automatic set_cpu(input bit rd, input bit wr, input int addr, input logic [31:0] d);
        cpu_rd = rd; cpu_wr = wr; cpu_addr = 9'(addr); cpu_wdata = d;
    endtask

    task automatic set_ld(input bit rq, input bit we, input int addr, input logic [31:0] d);
        ld_req = rq; ld_we = we; ld_addr = 9'(addr); ld_wdata = d;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cycle();
        cycle();
        rst = 1'b0;
    endtask

    initial begin
        int r;
        // Reset and preload every RAM word through the loader port.
        do_reset();
        for (int i = 0; i < 512; i++) begin
            set_ld(1'b1, 1'b1, i, 32'(i) * 32'h9E37_79B9 + 32'h0000_0101);
            cycle();
        end
        set_ld(1'b0, 1'b0, 0, 32'd0);
        cycle();

        // CPU write only, straight after reset.
        do_reset();
        set_cpu(1'b1 ^ 1'b1, 1'b1, 9'h010, 32'hDEAD_BEEF);
        cycle();
        chk("tp1_cnt", 32'(contention_cnt), 32'd0);
        // CPU read-back of the same word, then an idle cycle for the return.
        set_cpu(1'b1, 1'b0, 9'h010, 32'd0);
        cycle();
        set_cpu(1'b0, 1'b0, 0, 32'd0);
        chk("tp2_rdata", cpu_rdata, 32'hDEAD_BEEF);
        chk("tp2_rvalid", 32'(cpu_rvalid), 32'd1);
        cycle();

        // Simultaneous requests right after reset.
        do_reset();
        set_cpu(1'b1, 1'b0, 9'h004, 32'd0);
        set_ld(1'b1, 1'b1, 9'h008, 32'h1234_5678);
        cycle();
        set_cpu(1'b1, 1'b0, 9'h005, 32'd0);
        cycle();
        set_ld(1'b1, 1'b1, 9'h009, 32'h0BAD_F00D);
        cycle();
        set_cpu(1'b0, 1'b0, 0, 32'd0);
        set_ld(1'b0, 1'b0, 0, 32'd0);
        chk("tp3_cnt", 32'(contention_cnt), 32'd3);
        cycle();

        // Loader-only read stream of four words.
        for (int i = 0; i < 4; i++) begin
            set_ld(1'b1, 1'b0, i, 32'd0);
            cycle();
        end
        set_ld(1'b0, 1'b0, 0, 32'd0);
        cycle();

        // Reset in the cycle after a granted loader read, then a tie.
        set_ld(1'b1, 1'b0, 9'h003, 32'd0);
        cycle();
        set_ld(1'b0, 1'b0, 0, 32'd0);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        chk("tp5_ld_rvalid", 32'(ld_rvalid), 32'd0);
        set_cpu(1'b1, 1'b0, 9'h020, 32'd0);
        set_ld(1'b1, 1'b0, 9'h021, 32'd0);
        cycle();

        // Counter saturation: both sides requesting for 20 cycles.
        do_reset();
        for (int i = 0; i < 20; i++) begin
            set_cpu(1'b1, 1'b0, i, 32'd0);
            set_ld(1'b1, 1'b0, i + 64, 32'd0);
            cycle();
        end
        chk("tp6_cnt4", 32'(x_cnt), 32'd15);
        chk("tp6_cnt16", 32'(contention_cnt), 32'd20);
        set_cpu(1'b0, 1'b0, 0, 32'd0);
        set_ld(1'b0, 1'b0, 0, 32'd0);
        cycle();

        // Randomized traffic honouring the stall and loader-hold contracts.
        for (int n = 0; n < 400; n++) begin
            if (!e_stall) begin
                r = int'($urandom_range(0, 7));
                set_cpu(r >= 3 && r != 5 && r != 6, r >= 5,
                        int'($urandom_range(0, 31)), $urandom);
            end
            if (!(ld_req && !e_gnt) || $urandom_range(0, 15) == 0) begin
                set_ld($urandom_range(0, 2) != 0, 1'($urandom_range(0, 1)),
                       int'($urandom_range(0, 31)), $urandom);
            end
            rst = ($urandom_range(0, 59) == 0);
            cycle();
        end
        rst = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Two-requester arbiter sharing the single-port DATA_MEMORY between the processor data port (top_proc MemRead/MemWrite/dAddress/dWriteData) and a loader/debug port, used to preload or inspect RAM while the core runs.
- Round-robin grant, one access per cycle, 1-cycle read latency matching the synchronous RAM.
- Produces a stall to the core when it loses arbitration.
- Includes a saturating contention counter for bench and debug visibility.

Parameters:
- ADDR_W, 9, RAM word-address width (dAddress[8:0]).
- DATA_W, 32, data width.
- CNT_W, 16, width of the contention counter.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- cpu_rd  in  1  core read request (MemRead)
- cpu_wr  in  1  core write request (MemWrite)
- cpu_addr  in  ADDR_W  core address
- cpu_wdata  in  DATA_W  core write data
- cpu_stall  out  1  core request present but not granted this cycle
- cpu_rvalid  out  1  core read data valid
- cpu_rdata  out  DATA_W  core read data
- ld_req  in  1  loader request, held until ld_gnt
- ld_we  in  1  loader write (1) / read (0)
- ld_addr  in  ADDR_W  loader address
- ld_wdata  in  DATA_W  loader write data
- ld_gnt  out  1  loader request accepted this cycle
- ld_rvalid  out  1  loader read data valid
- ld_rdata  out  DATA_W  loader read data
- ram_we  out  1  to DATA_MEMORY.we
- ram_addr  out  ADDR_W  to DATA_MEMORY.addr
- ram_din  out  DATA_W  to DATA_MEMORY.din
- ram_dout  in  DATA_W  from DATA_MEMORY.dout (valid cycle after read issue)
- contention_cnt  out  CNT_W  cycles where both requesters were active

Behaviour:
- Request definitions: cpu_req = cpu_rd | cpu_wr. If cpu_rd and cpu_wr are both 1, treat the access as a write.
- Grant logic (combinational, same cycle):
  - Only one requester active: it wins.
  - Both active: the winner is the one NOT granted last (last_owner register).
- Grant effects:
  - cpu_stall = cpu_req & ~cpu_win.
  - ld_gnt = ld_req & ld_win.
- Last-owner update: last_owner updates on the clock edge only when a grant occurs; an idle cycle keeps it.
- RAM drive (combinational from winner):
  - ram_we = winner's write flag.
  - ram_addr and ram_din = winner's address/data.
  - No winner: ram_we = 0, ram_addr = 0, ram_din = 0.
- Read pipeline (registered):
  - rd_owner and rd_pending capture the granted read at the edge.
  - Next cycle: the matching *_rvalid = 1 and *_rdata = ram_dout.
  - The non-owner sees rdata = 0 and rvalid = 0.
  - Writes produce no rvalid.
- Throughput and latency:
  - Back-to-back grants every cycle; a read issued in cycle N returns in N+1, while cycle N+1 may issue a new access.
  - Write latency 0: RAM commits at the grant edge.
- Stall contract: while stalled, the core holds cpu_* stable; the arbiter needs no internal buffering.
- Loader handshake: ld_req/ld_addr/ld_we/ld_wdata held until ld_gnt. A loader request dropped before grant is simply not served.
- contention_cnt: +1 each cycle with cpu_req & ld_req; saturates at all-ones.
- Reset (rst = 1):
  - last_owner = LD, so the CPU wins the first tie.
  - rd_pending = 0, contention_cnt = 0.
  - All outputs forced low while rst is asserted: ram_we = 0, ld_gnt = 0, cpu_stall = 0, rvalids = 0.
- Reset mid-read: a read issued the cycle before rst produces no rvalid after reset.
- Address width: inputs are already ADDR_W; no wrap or translation is applied.

Decomposition:
- Package dmem_arb_pkg:
  - typedef owner_t {OWN_CPU, OWN_LD}
  - localparam defaults for ADDR_W / DATA_W / CNT_W
  - struct mem_req_t {we, addr, wdata}
- Sub-module rr_arbiter2: 2-way round-robin core.
  - Inputs: clk, rst, req[1:0], adv.
  - Output: gnt[1:0] one-hot.
  - Instantiated once. Everything else (read-return register, counter, muxes) stays in dmem_arbiter.

Test Plan:
- Reset, CPU write only: cpu_wr=1, addr=0x010, wdata=0xDEADBEEF → ram_we=1 same cycle, cpu_stall=0, contention_cnt=0.
- CPU read after that write: cpu_rd=1, addr=0x010 → next cycle cpu_rvalid=1, cpu_rdata=0xDEADBEEF, ld_rvalid=0.
- Simultaneous requests right after reset: CPU rd 0x004, loader wr 0x008=0x12345678 held → cycle 1: CPU granted, ld_gnt=0. Cycle 2: ld_gnt=1, cpu_stall=1. Cycle 3: CPU granted. contention_cnt=3.
- Loader-only read stream: 4 consecutive loader reads of 0x000–0x003 → ld_gnt=1 every cycle, ld_rvalid on cycles 2–5 with data in order, no bubbles.
- Reset mid-read: loader read granted, rst=1 the next cycle → ld_rvalid stays 0; after reset, a tie is won by the CPU.
- Counter saturation: CNT_W=4, both requesting for 20 cycles → contention_cnt stops at 15; grants keep alternating CPU/LD.
